// File: rtl/prn_line_pingpong.sv
// Two-bank ping-pong line buffer between the host print-data writer and the printhead shifter.
// Lines are committed per bank, read back on request, and faults are reported as one-cycle pulses.
module prn_line_pingpong #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LEN_A   = 720,
    parameter int unsigned LEN_B   = 800,
    parameter int unsigned LEN_RST = 720
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        PrintHead_Type,
    input  logic [7:0]        data_Type,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              line_done,
    input  logic              rd_start,
    input  logic              rd_req,
    output logic [DATA_W-1:0] PrnData,
    output logic              rd_valid,
    output logic              rd_done,
    output logic [1:0]        bank_full,
    output logic [ADDR_W-1:0] line_len,
    output logic              short_line_err,
    output logic              overrun_err,
    output logic              underrun_err
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } rd_state_t;

    rd_state_t state, state_n;

    logic [DATA_W-1:0]      mem [2*DEPTH];
    logic                   wr_bank, wr_bank_n;
    logic                   rd_bank, rd_bank_n;
    logic [ADDR_W-1:0]      wr_idx, wr_idx_n;
    logic [ADDR_W-1:0]      wr_len, wr_len_n;
    logic [ADDR_W-1:0]      rd_idx, rd_idx_n;
    logic [ADDR_W-1:0]      line_len_n;
    logic [ADDR_W-1:0]      eff_len, eff_len_n, count;
    logic [1:0][ADDR_W-1:0] bank_len, bank_len_n;
    logic [1:0]             bank_full_n;
    logic [DATA_W-1:0]      prn_n;
    logic                   wr_acc, release_c, commit_ok;
    logic                   wr_ready_n, rd_valid_n, rd_done_n;
    logic                   short_n, overrun_n, underrun_n;

    // Next-state logic for the write side, the read FSM and the bank flags.
    always_comb begin
        state_n     = state;
        wr_bank_n   = wr_bank;
        rd_bank_n   = rd_bank;
        wr_idx_n    = wr_idx;
        wr_len_n    = wr_len;
        rd_idx_n    = rd_idx;
        bank_len_n  = bank_len;
        bank_full_n = bank_full;
        prn_n       = PrnData;
        rd_valid_n  = 1'b0;
        rd_done_n   = 1'b0;
        short_n     = 1'b0;
        overrun_n   = 1'b0;
        underrun_n  = 1'b0;
        release_c   = 1'b0;

        case (PrintHead_Type)
            8'h01, 8'h06:               line_len_n = ADDR_W'(LEN_B);
            8'h02, 8'h03, 8'h04, 8'h05: line_len_n = ADDR_W'(LEN_A);
            default:                    line_len_n = line_len;
        endcase

        // The target length is frozen by the first accepted write of a line.
        eff_len = (wr_idx == '0) ? line_len : wr_len;
        wr_acc  = wr_req && wr_ready;
        count   = wr_idx + ADDR_W'(wr_acc);
        if (wr_acc) begin
            wr_idx_n = count;
            if (wr_idx == '0) begin
                wr_len_n = line_len;
            end
        end

        case (state)
            S_IDLE: begin
                if (rd_start) begin
                    if (!bank_full[rd_bank]) begin
                        underrun_n = 1'b1;
                    end else if (bank_len[rd_bank] == '0) begin
                        release_c = 1'b1;
                    end else begin
                        state_n  = S_READ;
                        rd_idx_n = '0;
                    end
                end
            end
            S_READ: begin
                if (rd_req) begin
                    rd_valid_n = 1'b1;
                    rd_idx_n   = rd_idx + ADDR_W'(1);
                    case (data_Type)
                        8'h02:   prn_n = '1;
                        8'h03:   prn_n = mem[{rd_bank, rd_idx}];
                        default: prn_n = '0;
                    endcase
                    if (rd_idx == bank_len[rd_bank] - ADDR_W'(1)) begin
                        release_c = 1'b1;
                        state_n   = S_IDLE;
                    end
                end
            end
        endcase

        if (release_c) begin
            bank_full_n[rd_bank] = 1'b0;
            rd_bank_n            = ~rd_bank;
            rd_done_n            = 1'b1;
        end

        // A bank being released this cycle may be re-committed in the same cycle.
        commit_ok = !bank_full[wr_bank] || (release_c && (rd_bank == wr_bank));
        if (line_done) begin
            wr_idx_n = '0;
            if (commit_ok) begin
                bank_len_n[wr_bank]  = count;
                bank_full_n[wr_bank] = 1'b1;
                wr_bank_n            = ~wr_bank;
                short_n              = (count != eff_len);
            end else begin
                overrun_n = 1'b1;
            end
        end

        eff_len_n  = (wr_idx_n == '0) ? line_len_n : wr_len_n;
        wr_ready_n = !bank_full_n[wr_bank_n] && (wr_idx_n < eff_len_n);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_idx         <= '0;
            wr_len         <= '0;
            rd_idx         <= '0;
            bank_len       <= '0;
            bank_full      <= '0;
            line_len       <= ADDR_W'(LEN_RST);
            wr_ready       <= 1'b0;
            PrnData        <= '0;
            rd_valid       <= 1'b0;
            rd_done        <= 1'b0;
            short_line_err <= 1'b0;
            overrun_err    <= 1'b0;
            underrun_err   <= 1'b0;
        end else begin
            state          <= state_n;
            wr_bank        <= wr_bank_n;
            rd_bank        <= rd_bank_n;
            wr_idx         <= wr_idx_n;
            wr_len         <= wr_len_n;
            rd_idx         <= rd_idx_n;
            bank_len       <= bank_len_n;
            bank_full      <= bank_full_n;
            line_len       <= line_len_n;
            wr_ready       <= wr_ready_n;
            PrnData        <= prn_n;
            rd_valid       <= rd_valid_n;
            rd_done        <= rd_done_n;
            short_line_err <= short_n;
            overrun_err    <= overrun_n;
            underrun_err   <= underrun_n;
        end
    end

    // Line storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
    end
endmodule
